// File: rtl/mem_responder_if.sv
// Load/store request and response bundle between the control unit (master)
// and the data-memory responder (slave). req_be exists only when
// MEM_RESPONDER_BYTE_STROBE_EN is defined.
interface mem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
   logic [3:0]  req_be;
`endif
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
   modport master (output req_valid, req_write, req_addr, req_wdata, req_be,
                   input  req_ready, resp_valid, resp_rdata, resp_err);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_be,
                   output req_ready, resp_valid, resp_rdata, resp_err);
`else
   modport master (output req_valid, req_write, req_addr, req_wdata,
                   input  req_ready, resp_valid, resp_rdata, resp_err);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                   output req_ready, resp_valid, resp_rdata, resp_err);
`endif
endinterface

// File: rtl/mem_responder.sv
// Multicycle data-memory responder. Accepts one word load/store at a time,
// executes it LATENCY cycles after acceptance and returns a one-cycle
// response pulse. Misaligned or out-of-range addresses return resp_err.
// Optional byte strobes: define MEM_RESPONDER_BYTE_STROBE_EN.
// LATENCY must lie in 1..15; DEPTH_LOG2 must not exceed 29.
module mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic           clk,
   input  logic           rst,
   mem_responder_if.slave bus
);
   localparam int WORDS = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                stateQ, stateD;
   logic [3:0]            counter;
   logic                  accept, execute;
   logic                  writeQ;
   logic [31:0]           addrQ, wdataQ;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
   logic [3:0]            beQ;
`endif
   logic [31:0]           rdataQ;
   logic                  errQ;
   logic                  accessErr;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic [31:0]           mem [WORDS];

   // Address checks and word index come from the latched request, never the live bus.
   assign accessErr = (addrQ[1:0] != 2'b00) || ((addrQ >> (DEPTH_LOG2 + 2)) != 32'd0);
   assign wordIdx   = addrQ[DEPTH_LOG2+1:2];

   assign bus.resp_rdata = rdataQ;
   assign bus.resp_err   = errQ;

   // State register; reset wins over any request presented on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) stateQ <= IDLE;
      else      stateQ <= stateD;
   end

   // Next state plus handshake decode: ready only in IDLE, pulse only in RESP.
   always_comb begin
      stateD         = stateQ;
      accept         = 1'b0;
      execute        = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (stateQ)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept = 1'b1;
               stateD = BUSY;
            end
         end
         BUSY: begin
            if (counter == 4'd0) begin
               execute = 1'b1;
               stateD  = RESP;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            stateD         = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   // Capture request fields; they only matter at the acceptance edge.
   always_ff @(posedge clk) begin
      if (rst && accept) begin
         writeQ <= bus.req_write;
         addrQ  <= bus.req_addr;
         wdataQ <= bus.req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
         beQ    <= bus.req_be;
`endif
      end
   end

   // Latency countdown plus response data/error registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         counter <= 4'd0;
         rdataQ  <= 32'd0;
         errQ    <= 1'b0;
      end else begin
         if (accept)
            counter <= 4'(LATENCY - 1);
         else if (stateQ == BUSY && counter != 4'd0)
            counter <= counter - 4'd1;

         if (execute) begin
            errQ   <= accessErr;
            // Read returns the contents before any same-edge write.
            rdataQ <= (!writeQ && !accessErr) ? mem[wordIdx] : 32'd0;
         end else if (stateQ == RESP) begin
            errQ   <= 1'b0;
            rdataQ <= 32'd0;
         end
      end
   end

   // Array write; gated by rst so a reset edge abandons the pending store.
   always_ff @(posedge clk) begin
      if (rst && execute && writeQ && !accessErr) begin
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
         for (int b = 0; b < 4; b++)
            if (beQ[b]) mem[wordIdx][8*b +: 8] <= wdataQ[8*b +: 8];
`else
         mem[wordIdx] <= wdataQ;
`endif
      end
   end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multicycle data-memory responder: the memory-side end of the load/store interface driven by the processor control unit.
- Accepts one word read or write request at a time over a valid/ready request channel.
- Holds an internal word array and returns a single-cycle response pulse after a fixed, parameterised latency.
- Flags misaligned and out-of-range accesses as errors.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words in the array (default 256 words, byte address range 0x000–0x3FF).
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request.
- resp_valid  output  1  single-cycle response pulse.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  access error; valid only with resp_valid.

Behaviour:
- Reset, sampled when rst=0 at a clk edge:
  - state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - The array is not cleared.
- States are IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted at an edge where req_valid=1 and req_ready=1.
  - On acceptance, latch req_write, req_addr and req_wdata; load counter=LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - Counter decrements each edge.
  - At the edge where counter==0, the access executes and the state moves to RESP.
- Access execution:
  - err = (addr[1:0] != 0) or (addr[31:DEPTH_LOG2+2] != 0).
  - Word index = addr[DEPTH_LOG2+1:2].
  - Store with err=0: write the array at that edge.
  - Load with err=0: resp_rdata is registered from the array (pre-write contents of that word).
  - err=1: no write, resp_rdata=0.
- RESP:
  - resp_valid=1 and req_ready=0 for exactly one cycle.
  - resp_err and resp_rdata are held stable during that cycle.
  - Next edge returns to IDLE and clears resp_valid, resp_err and resp_rdata to 0.
- Timing:
  - Acceptance at edge E0 gives resp_valid high in the cycle after edge E0+LATENCY.
  - Minimum request spacing is LATENCY+2 cycles.
- No response backpressure: the initiator must sample in the pulse cycle.
- req_valid while req_ready=0 is ignored; nothing is queued.
- Request fields are don't-care except at the acceptance edge.
- Reset mid-operation, in BUSY or RESP:
  - The pending access is abandoned: no write, no response.
  - Return to the IDLE reset values.
- A read issued after a write to the same word returns the new data.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.

Optional Feature:
- Macro MEM_RESPONDER_BYTE_STROBE_EN.
- Defined:
  - Adds input req_be[3:0], latched at acceptance.
  - A store writes only bytes whose strobe is 1 (bit i controls bits [8i+7:8i]).
  - req_be=0 is a legal no-op store, with resp_err per address only.
  - Loads ignore req_be.
- Undefined:
  - The port is absent.
  - All stores are full-word.

Test Plan:
- Reset: rst=0 for 2 cycles then 1 → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 in the first cycle after release.
- Write then read, LATENCY=2:
  - Store 0xDEADBEEF to 0x010 accepted at E0 → resp_valid=1 in the cycle after E2 with resp_err=0 and resp_rdata=0.
  - Load 0x010 → resp_rdata=0xDEADBEEF.
- Errors:
  - Store to 0x013 → resp_err=1.
  - A following load from 0x010 still returns 0xDEADBEEF.
  - Load from 0x400 (DEPTH_LOG2=8) → resp_err=1, resp_rdata=0.
- Busy ignore: hold req_valid=1 continuously with differing addresses → exactly one acceptance per LATENCY+2 cycles; req_ready=0 in BUSY and RESP.
- Reset mid-op: store 0x12345678 to 0x020, assert rst=0 one cycle after acceptance → no resp_valid; a later load of 0x020 returns the prior contents.
- Strobe, macro defined: word 0x030 = 0x11223344; store 0xAABBCCDD with req_be=4'b0101 → load 0x030 returns 0x11BB33DD.
